uart_tx_responder: RTL and testbench

- Memory-mapped UART transmitter that sits on the RISCV core's bus as a responder.
- Decodes the core's address/write strobe, accepts bytes into a TX FIFO, and serialises them 8N1, LSB first, on txd.
- Returns status and configuration on read.
- The system read mux selects this block's read data when hit=1.

---
 rtl/uart_tx_responder.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter acting as a bus responder.
// Bus writes push bytes into a TX FIFO. A serialiser drains the FIFO LSB first on txd,
// and starts the next frame straight after a stop bit, with no idle gap.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   address      bus address; window is BASE_ADDR..BASE_ADDR+15, offset = address[3:2]
//   writeData    bus write data
//   writeEnable  bus write strobe, one write per high cycle
//   readData     combinational register read data, 0 when not hit
//   hit          address falls inside this block's 16-byte window
//   txd          registered serial output, idle high
//   txBusy       serialiser active or FIFO not empty
//
// Register map:
//   0x0 DATA     write pushes [7:0]; reads 0
//   0x4 STATUS   read {count[12:8], overflow[3], active[2], full[1], empty[0]};
//                write [3]=1 clears overflow
//   0x8 DIVISOR  [15:0] clocks per bit; writing 0 stores 1
//   0xC reserved
module uart_tx_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned DEFAULT_DIVISOR = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        writeEnable,
  output logic [31:0] readData,
  output logic        hit,
  output logic        txd,
  output logic        txBusy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} txStateT;

  // Bus decode
  logic       busWrite;
  logic [1:0] offset;
  logic       unusedBits;

  assign hit        = (address[31:4] == BASE_ADDR[31:4]);
  assign offset     = address[3:2];
  assign busWrite   = hit & writeEnable;
  assign unusedBits = ^{writeData[31:16], address[1:0]};

  // Registers
  logic [15:0]     divisorQ, divisorD;
  logic            overflowQ, overflowD;
  logic [7:0]      fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [CntW-1:0] countQ, countD;

  txStateT     stateQ, stateD;
  logic [15:0] bitCntQ, bitCntD;
  logic [2:0]  bitIdxQ, bitIdxD;
  logic [7:0]  shiftQ, shiftD;
  logic [15:0] curDivQ, curDivD;
  logic        txdQ, txdD;

  logic fifoEmpty, fifoFull;
  logic pushReq, pushOk, drop, pop;
  logic bitEnd, loadFrame;

  assign fifoEmpty = (countQ == '0);
  assign fifoFull  = (countQ == CntW'(FIFO_DEPTH));
  assign bitEnd    = (bitCntQ == (curDivQ - 16'd1));
  // Load a new frame from IDLE, or back-to-back at the very last cycle of a stop bit.
  assign loadFrame = !fifoEmpty && ((stateQ == StIdle) || ((stateQ == StStop) && bitEnd));
  assign pop       = loadFrame;

  // A full FIFO still accepts a push when the serialiser pops on the same edge.
  assign pushReq = busWrite && (offset == 2'd0);
  assign pushOk  = pushReq && (!fifoFull || pop);
  assign drop    = pushReq && fifoFull && !pop;

  // FIFO and control register next state
  always_comb begin
    wrPtrD    = wrPtrQ;
    rdPtrD    = rdPtrQ;
    countD    = countQ;
    overflowD = overflowQ;
    divisorD  = divisorQ;

    if (pushOk) wrPtrD = wrPtrQ + PtrW'(1);
    if (pop)    rdPtrD = rdPtrQ + PtrW'(1);
    unique case ({pushOk, pop})
      2'b10:   countD = countQ + CntW'(1);
      2'b01:   countD = countQ - CntW'(1);
      default: countD = countQ;
    endcase

    if (drop) begin
      overflowD = 1'b1;
    end else if (busWrite && (offset == 2'd1) && writeData[3]) begin
      overflowD = 1'b0;
    end

    if (busWrite && (offset == 2'd2)) begin
      divisorD = (writeData[15:0] == 16'd0) ? 16'd1 : writeData[15:0];
    end
  end

  // Serialiser next state
  always_comb begin
    stateD  = stateQ;
    bitCntD = bitCntQ;
    bitIdxD = bitIdxQ;
    shiftD  = shiftQ;
    curDivD = curDivQ;

    if (loadFrame) begin
      shiftD  = fifoMem[rdPtrQ];
      curDivD = divisorQ;
      stateD  = StStart;
      bitCntD = 16'd0;
    end else begin
      unique case (stateQ)
        StIdle: ;
        StStart: begin
          if (bitEnd) begin
            stateD  = StData;
            bitIdxD = 3'd0;
            bitCntD = 16'd0;
          end else begin
            bitCntD = bitCntQ + 16'd1;
          end
        end
        StData: begin
          if (bitEnd) begin
            bitCntD = 16'd0;
            if (bitIdxQ == 3'd7) stateD = StStop;
            else                 bitIdxD = bitIdxQ + 3'd1;
          end else begin
            bitCntD = bitCntQ + 16'd1;
          end
        end
        StStop: begin
          if (bitEnd) begin
            stateD  = StIdle;
            bitCntD = 16'd0;
          end else begin
            bitCntD = bitCntQ + 16'd1;
          end
        end
        default: stateD = StIdle;
      endcase
    end

    // txd is decoded from next state so the line level changes on the same edge as the FSM.
    unique case (stateD)
      StStart: txdD = 1'b0;
      StData:  txdD = shiftD[bitIdxD];
      default: txdD = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divisorQ  <= 16'(DEFAULT_DIVISOR);
      overflowQ <= 1'b0;
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
      stateQ    <= StIdle;
      bitCntQ   <= 16'd0;
      bitIdxQ   <= 3'd0;
      shiftQ    <= 8'd0;
      curDivQ   <= 16'(DEFAULT_DIVISOR);
      txdQ      <= 1'b1;
    end else begin
      divisorQ  <= divisorD;
      overflowQ <= overflowD;
      wrPtrQ    <= wrPtrD;
      rdPtrQ    <= rdPtrD;
      countQ    <= countD;
      stateQ    <= stateD;
      bitCntQ   <= bitCntD;
      bitIdxQ   <= bitIdxD;
      shiftQ    <= shiftD;
      curDivQ   <= curDivD;
      txdQ      <= txdD;
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtrQ] <= writeData[7:0];
  end

  assign txd    = txdQ;
  assign txBusy = (stateQ != StIdle) || !fifoEmpty;

  // Zero-wait, side-effect-free read mux
  always_comb begin
    readData = 32'd0;
    if (hit) begin
      unique case (offset)
        2'd1: begin
          readData[0]    = fifoEmpty;
          readData[1]    = fifoFull;
          readData[2]    = (stateQ != StIdle);
          readData[3]    = overflowQ;
          readData[12:8] = 5'(countQ);
        end
        2'd2:    readData[15:0] = divisorQ;
        default: readData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_responder.sv
module tb_uart_tx_responder;

  localparam logic [31:0] Base   = 32'h8000_0000;
  localparam logic [31:0] Data   = Base;
  localparam logic [31:0] Status = Base + 32'd4;
  localparam logic [31:0] Div    = Base + 32'd8;
  localparam logic [31:0] Rsvd   = Base + 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [31:0] readData;
  logic        hit;
  logic        txd;
  logic        txBusy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected readData for a read
    bit          expHit;
  } vecT;

  vecT vecs[18];

  uart_tx_responder #(
    .BASE_ADDR      (Base),
    .FIFO_DEPTH     (8),
    .DEFAULT_DIVISOR(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .writeData  (writeData),
    .writeEnable(writeEnable),
    .readData   (readData),
    .hit        (hit),
    .txd        (txd),
    .txBusy     (txBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write lands on the posedge inside this task; returns 1 time unit after that edge.
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address     = a;
    writeData   = d;
    writeEnable = 1'b1;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
  endtask

  task automatic busRead(input string name, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readData, exp);
  endtask

  // Samples txd once per cycle for a whole frame starting at the next posedge.
  task automatic expectFrame(input logic [7:0] b, input int div, input string name);
    logic [9:0] f;
    int         bad;
    logic       badVal;
    f      = {1'b1, b, 1'b0};
    bad    = -1;
    badVal = 1'b0;
    for (int i = 0; i < 10 * div; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((txd !== f[i / div]) && (bad < 0)) begin
        bad    = i;
        badVal = txd;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: cycle %0d of frame txd got %b expected %b", name, bad, badVal,
               f[bad / div]);
    end
  endtask

  initial begin
    address     = 32'd0;
    writeData   = 32'd0;
    writeEnable = 1'b0;
    reset       = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset state
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset txBusy", {31'd0, txBusy}, 32'd0);

    // Register-access vectors
    vecs[0]  = '{1'b0, Status,             32'h0000_0001, 1'b1};
    vecs[1]  = '{1'b0, Div,                32'd16,        1'b1};
    vecs[2]  = '{1'b0, Data,               32'd0,         1'b1};
    vecs[3]  = '{1'b0, Rsvd,               32'd0,         1'b1};
    vecs[4]  = '{1'b0, Base + 32'h14,      32'd0,         1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0008,      32'd0,         1'b0};
    vecs[6]  = '{1'b1, Div,                32'hABCD_0003, 1'b1};
    vecs[7]  = '{1'b0, Div,                32'd3,         1'b1};
    vecs[8]  = '{1'b0, Base + 32'h0A,      32'd3,         1'b1};
    vecs[9]  = '{1'b1, 32'h7FFF_FFF8,      32'd9,         1'b0};
    vecs[10] = '{1'b0, Div,                32'd3,         1'b1};
    vecs[11] = '{1'b1, Rsvd,               32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{1'b0, Rsvd,               32'd0,         1'b1};
    vecs[13] = '{1'b1, Status,             32'hFFFF_FFF7, 1'b1};
    vecs[14] = '{1'b0, Status,             32'h0000_0001, 1'b1};
    vecs[15] = '{1'b1, Div,                32'd0,         1'b1};
    vecs[16] = '{1'b0, Div,                32'd1,         1'b1};
    vecs[17] = '{1'b1, Div,                32'd16,        1'b1};

    for (int v = 0; v < 18; v++) begin
      if (vecs[v].isWrite) begin
        busWrite(vecs[v].addr, vecs[v].data);
      end else begin
        address = vecs[v].addr;
        #1;
        check($sformatf("vec%0d readData", v), readData, vecs[v].data);
        check($sformatf("vec%0d hit", v), {31'd0, hit}, {31'd0, vecs[v].expHit});
      end
    end
    busRead("div restored", Div, 32'd16);

    // Single frame at divisor 4
    busWrite(Div, 32'd4);
    busWrite(Data, 32'h55);
    check("busy after push", {31'd0, txBusy}, 32'd1);
    expectFrame(8'h55, 4, "frame 0x55");
    @(posedge clk);
    #1;
    check("idle after 0x55", {31'd0, txBusy}, 32'd0);

    // Nine back-to-back bytes at divisor 2, tenth overflows
    busWrite(Div, 32'd2);
    busWrite(Data, 32'hA0);
    fork
      begin
        for (int k = 1; k < 9; k++) busWrite(Data, 32'hA0 + k);
        busRead("status full", Status, 32'h0000_0806);
        busWrite(Data, 32'hFF);
        busRead("status overflow", Status, 32'h0000_080E);
      end
      begin
        for (int k = 0; k < 9; k++) expectFrame(8'(8'hA0 + k), 2, $sformatf("burst frame %0d", k));
      end
    join
    @(posedge clk);
    #1;
    busRead("status drained", Status, 32'h0000_0009);
    check("idle after burst", {31'd0, txBusy}, 32'd0);

    // Overflow clear, divisor 0 stores 1
    busWrite(Status, 32'h8);
    busRead("overflow cleared", Status, 32'h0000_0001);
    busWrite(Div, 32'd0);
    busRead("div zero reads 1", Div, 32'd1);
    busWrite(Data, 32'h3C);
    expectFrame(8'h3C, 1, "frame div1");
    @(posedge clk);
    #1;
    check("idle after div1", {31'd0, txBusy}, 32'd0);

    // Mid-frame divisor change only affects the next frame
    busWrite(Div, 32'd4);
    busWrite(Data, 32'hC3);
    fork
      begin
        expectFrame(8'hC3, 4, "frame old div");
        expectFrame(8'h5A, 8, "frame new div");
      end
      begin
        repeat (3) @(posedge clk);
        busWrite(Div, 32'd8);
        busWrite(Data, 32'h5A);
      end
    join
    @(posedge clk);
    #1;
    check("idle after div change", {31'd0, txBusy}, 32'd0);
    busRead("div reads 8", Div, 32'd8);

    // Asynchronous reset mid-DATA
    busWrite(Div, 32'd4);
    busWrite(Data, 32'h00);
    busWrite(Data, 32'h00);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("txd low mid data", {31'd0, txd}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("txd async reset", {31'd0, txd}, 32'd1);
    check("busy async reset", {31'd0, txBusy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      int lowSeen;
      lowSeen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (txd !== 1'b1) lowSeen++;
      end
      check("no residual bits", lowSeen, 32'd0);
    end
    busRead("status after reset", Status, 32'h0000_0001);
    busRead("div after reset", Div, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
